// File: rtl/sorter_pkg.sv
// Shared sorter definitions: weight thresholds, group codes, feeder states.
// Both the sorter and the feeder import this package so their thresholds agree.
package sorter_pkg;

  localparam logic [11:0] THR_1 = 12'd200;
  localparam logic [11:0] THR_2 = 12'd500;
  localparam logic [11:0] THR_3 = 12'd800;
  localparam logic [11:0] THR_4 = 12'd1000;
  localparam logic [11:0] THR_5 = 12'd2000;

  localparam logic [2:0] GRP_NONE = 3'd0;
  localparam logic [2:0] GRP_1    = 3'd1;
  localparam logic [2:0] GRP_2    = 3'd2;
  localparam logic [2:0] GRP_3    = 3'd3;
  localparam logic [2:0] GRP_4    = 3'd4;
  localparam logic [2:0] GRP_5    = 3'd5;
  localparam logic [2:0] GRP_6    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_GAP
  } feeder_state_t;

  function automatic logic [2:0] weight_to_group(input logic [11:0] w);
    logic [2:0] g;
    if (w == 12'd0)      g = GRP_NONE;
    else if (w <= THR_1) g = GRP_1;
    else if (w <= THR_2) g = GRP_2;
    else if (w <= THR_3) g = GRP_3;
    else if (w <= THR_4) g = GRP_4;
    else if (w <= THR_5) g = GRP_5;
    else                 g = GRP_6;
    return g;
  endfunction

endpackage

// File: rtl/weight_fifo.sv
// Single-clock FIFO for queued package weights.
// No bypass: a push into an empty FIFO is readable only after the edge.
module weight_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/package_feeder.sv
// Conveyor weight transmitter: queues loader weights and drives
// one fixed-length nonzero pulse plus zero gap per package.
module package_feeder
  import sorter_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [11:0] LoadWeight,
  input  logic        LoadValid,
  output logic        LoadReady,
  input  logic        Enable,
  output logic [11:0] Weight,
  output logic [2:0]  ExpectedGrp,
  output logic [7:0]  ItemsSent,
  output logic        Busy,
  output logic        Empty
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);

  feeder_state_t    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [11:0]      weight_n;
  logic [2:0]       grp_n;
  logic [7:0]       items_n;
  logic [11:0]      head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             start;

  // Zero weights finish the handshake but never enter the queue.
  assign push      = LoadValid && (LoadWeight != 12'd0);
  assign LoadReady = !full;
  assign Empty     = empty;
  assign Busy      = (state != ST_IDLE);

  weight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (12)
  ) u_fifo (
    .clk   (CLK),
    .reset (Reset),
    .push  (push),
    .pop   (pop),
    .wdata (LoadWeight),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      Weight      <= 12'd0;
      ExpectedGrp <= GRP_NONE;
      ItemsSent   <= 8'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      Weight      <= weight_n;
      ExpectedGrp <= grp_n;
      ItemsSent   <= items_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    weight_n = Weight;
    grp_n    = ExpectedGrp;
    items_n  = ItemsSent;
    pop      = 1'b0;
    // Enable only matters where a new package may begin.
    start    = Enable && !empty &&
               ((state == ST_IDLE) ||
                (state == ST_GAP && cnt == '0));

    unique case (state)
      ST_IDLE: ;
      ST_PRESENT: begin
        if (cnt == '0) begin
          state_n  = ST_GAP;
          cnt_n    = GAP_M1;
          weight_n = 12'd0;
          grp_n    = GRP_NONE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase

    if (start) begin
      state_n  = ST_PRESENT;
      cnt_n    = HOLD_M1;
      weight_n = head;
      grp_n    = weight_to_group(head);
      pop      = 1'b1;
      items_n  = ItemsSent + 8'd1;
    end
  end

endmodule

// File: doc/package_feeder.md
Name: package_feeder

Overview:
- Transmit side of the conveyor weight interface: queues package weights from a loader and drives them onto the 12-bit Weight line feeding the package sorter.
- Each package is a nonzero Weight pulse of fixed length followed by a mandatory zero gap, so the sorter sees one 0-to-nonzero edge per package.
- Also reports the expected sort group of the weight it is presenting and a count of packages sent; benches use these as a scoreboard reference.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=2)
- HOLD_CYCLES, 4, CLK cycles a nonzero weight is held (>=1)
- GAP_CYCLES, 2, CLK cycles of Weight=0 after each package (>=1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high
- LoadWeight  in  12  weight to enqueue
- LoadValid  in  1  LoadWeight valid this cycle
- LoadReady  out  1  FIFO can accept; equals !full, combinational
- Enable  in  1  permit starting new packages
- Weight  out  12  registered conveyor weight, to sorter Weight
- ExpectedGrp  out  3  registered group code of the Weight being driven (0 when Weight=0)
- ItemsSent  out  8  packages started since reset; wraps 255->0
- Busy  out  1  high in PRESENT or GAP
- Empty  out  1  FIFO empty

Behaviour:
- Reset (async) forces: state IDLE, FIFO empty, Weight=0, ExpectedGrp=0, ItemsSent=0, Busy=0, Empty=1, LoadReady=1.
- Load: push when LoadValid && LoadReady at a rising edge. LoadWeight==0 completes the handshake but is discarded, because a zero weight is not a package. LoadValid while full is ignored, with no overwrite.
- Weight changes only on rising CLK, so it is stable at the sorter's falling-edge sample point.
- FSM states: IDLE, PRESENT, GAP.
  - IDLE -> PRESENT when Enable && !Empty. On that edge: Weight<=head, ExpectedGrp<=group(head), pop, ItemsSent+1.
  - PRESENT lasts exactly HOLD_CYCLES cycles. On its last edge: Weight<=0, ExpectedGrp<=0, -> GAP.
  - GAP lasts exactly GAP_CYCLES cycles. On its last edge, if Enable && !Empty, go directly to PRESENT with the same actions as from IDLE. Otherwise -> IDLE.
- Per-package waveform: Weight nonzero for exactly HOLD_CYCLES cycles, then zero for >= GAP_CYCLES cycles.
- Enable deasserted mid-PRESENT or mid-GAP: the current package and its gap complete unchanged; the FSM then goes to IDLE. Enable is sampled only at package start.
- Push and pop on the same edge: both take effect and the count is unchanged. A push into an empty FIFO is not visible for pop until the next edge (no bypass).
- Group function (12-bit unsigned W):
  - 0 -> 0
  - 1..200 -> 1
  - 201..500 -> 2
  - 501..800 -> 3
  - 801..1000 -> 4
  - 1001..2000 -> 5
  - >2000 -> 6
- Internal hold/gap counter is sized to max(HOLD_CYCLES, GAP_CYCLES).
- Reset mid-package: Weight drops to 0 immediately (async). Queued weights are lost.

Decomposition:
- Shared package sorter_pkg holds:
  - group threshold constants 200/500/800/1000/2000
  - 3-bit group code constants GRP_NONE..GRP_6
  - a pure function weight_to_group(12-bit) -> 3-bit
  - the FSM state enum
- The sorter and the feeder both use sorter_pkg so their thresholds cannot diverge.
- One sub-module, weight_fifo: synchronous single-clock FIFO, DEPTH x 12, with full/empty flags and async active-high reset.

Test Plan:
- Load 150, 350, 2500, then Enable=1 -> Weight = 150 x4, 0 x2, 350 x4, 0 x2, 2500 x4, 0 thereafter; ExpectedGrp 1, 2, 6; ItemsSent=3; Busy low and Empty high at end.
- Enable=0, load 8 weights (10..80) -> LoadReady=0 after the 8th; 9th load of 999 is ignored. Enable=1 -> exactly 8 packages 10..80 in order.
- Load 0, 0, 700 -> only 700 is sent, ExpectedGrp=3, ItemsSent=1.
- Boundary loads 200, 201, 1000, 1001, 2000, 2001, 4095 -> ExpectedGrp 1, 2, 4, 5, 5, 6, 6.
- Load 300, 400; drop Enable in cycle 2 of the first PRESENT -> 300 held 4 cycles, 2-cycle gap, then IDLE with 400 still queued. Re-enable -> 400 sent.
- Assert Reset in cycle 3 of a PRESENT with 3 queued -> Weight=0 before the next edge, ItemsSent=0, Empty=1; nothing sent after release.
